// File: rtl/instruction_fetch_unit_pkg.sv
// Shared fetch/decode definitions: widths, instruction field positions, opcodes, register names,
// and the fetch FSM encoding (S_NOP_WAIT only exists when FETCH_NOP_DELAY_EN is defined).
package instruction_fetch_unit_pkg;

  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned INSTR_W = 28;
  localparam int unsigned OP_W    = 4;
  localparam int unsigned FIELD_W = 8;
  localparam int unsigned DELAY_W = 24;

  localparam int unsigned OP_MSB   = 27;
  localparam int unsigned OP_LSB   = 24;
  localparam int unsigned DST_MSB  = 23;
  localparam int unsigned DST_LSB  = 16;
  localparam int unsigned SRC1_MSB = 15;
  localparam int unsigned SRC1_LSB = 8;
  localparam int unsigned SRC0_MSB = 7;
  localparam int unsigned SRC0_LSB = 0;
  localparam int unsigned IMM_MSB  = 15;
  localparam int unsigned IMM_LSB  = 0;

  localparam logic [OP_W-1:0] OP_NOP = 4'h0;
  localparam logic [OP_W-1:0] OP_STO = 4'h1;
  localparam logic [OP_W-1:0] OP_ADD = 4'h2;
  localparam logic [OP_W-1:0] OP_SUB = 4'h3;
  localparam logic [OP_W-1:0] OP_BLE = 4'h4;
  localparam logic [OP_W-1:0] OP_JMP = 4'h5;
  localparam logic [OP_W-1:0] OP_LED = 4'h6;

  localparam logic [FIELD_W-1:0] REG_R0  = 8'h00;
  localparam logic [FIELD_W-1:0] REG_R1  = 8'h01;
  localparam logic [FIELD_W-1:0] REG_R2  = 8'h02;
  localparam logic [FIELD_W-1:0] REG_R3  = 8'h03;
  localparam logic [FIELD_W-1:0] REG_LED = 8'hFF;

`ifdef FETCH_NOP_DELAY_EN
  typedef enum logic [1:0] {
    S_RESET    = 2'd0,
    S_RUN      = 2'd1,
    S_NOP_WAIT = 2'd2
  } fetch_state_e;
`else
  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_RUN   = 2'd1
  } fetch_state_e;
`endif

  function automatic logic [OP_W-1:0] get_op(input logic [INSTR_W-1:0] word);
    return word[OP_MSB:OP_LSB];
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_program_counter.sv
// Program counter: synchronous reset, load, hold, otherwise increment with modulo-2^16 wrap.
module instruction_fetch_unit_program_counter
  import instruction_fetch_unit_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_load_value,
  input  logic              i_hold,
  output logic [ADDR_W-1:0] o_pc
);

  logic [ADDR_W-1:0] r_pc;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pc <= '0;
    end else if (i_load) begin
      r_pc <= i_load_value;
    end else if (!i_hold) begin
      r_pc <= r_pc + ADDR_W'(1);
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch/decode front end: PC, instruction register and field split for execute.
// FETCH_NOP_DELAY_EN makes a NOP with nonzero IR[23:0] insert that many extra bubbles.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
(
  input  logic        Clock,
  input  logic        Reset,
  output logic [15:0] oAddress,
  input  logic [27:0] iInstruction,
  input  logic        iStall,
  input  logic        iBranchTaken,
  input  logic [15:0] iBranchTarget,
  output logic        oValid,
  output logic [15:0] oPC,
  output logic [3:0]  oOperation,
  output logic [7:0]  oDestination,
  output logic [7:0]  oSource1,
  output logic [7:0]  oSource0,
  output logic [15:0] oImmediate
);

  fetch_state_e       r_state, w_state_next;
  logic [INSTR_W-1:0] r_ir, w_ir_next;
  logic               r_valid, w_valid_next;
  logic [ADDR_W-1:0]  r_ir_pc, w_ir_pc_next;
  logic [ADDR_W-1:0]  w_pc;
  logic               w_wait_active;

`ifdef FETCH_NOP_DELAY_EN
  logic [DELAY_W-1:0] r_delay, w_delay_next;
  assign w_wait_active = (r_state == S_NOP_WAIT);
`else
  assign w_wait_active = 1'b0;
`endif

  // A branch overrides both stall and NOP wait inside the PC's own load priority.
  instruction_fetch_unit_program_counter u_program_counter (
    .i_clk        (Clock),
    .i_rst        (Reset),
    .i_load       (iBranchTaken),
    .i_load_value (iBranchTarget),
    .i_hold       (iStall | w_wait_active),
    .o_pc         (w_pc)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= S_RESET;
      r_ir    <= '0;
      r_valid <= 1'b0;
      r_ir_pc <= '0;
`ifdef FETCH_NOP_DELAY_EN
      r_delay <= '0;
`endif
    end else begin
      r_state <= w_state_next;
      r_ir    <= w_ir_next;
      r_valid <= w_valid_next;
      r_ir_pc <= w_ir_pc_next;
`ifdef FETCH_NOP_DELAY_EN
      r_delay <= w_delay_next;
`endif
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_ir_next    = r_ir;
    w_valid_next = r_valid;
    w_ir_pc_next = r_ir_pc;
`ifdef FETCH_NOP_DELAY_EN
    w_delay_next = r_delay;
`endif
    if (iBranchTaken) begin
      w_state_next = S_RUN;
      w_ir_next    = '0;
      w_valid_next = 1'b0;
      w_ir_pc_next = '0;
`ifdef FETCH_NOP_DELAY_EN
      w_delay_next = '0;
`endif
    end else if (!iStall) begin
`ifdef FETCH_NOP_DELAY_EN
      if (r_state == S_NOP_WAIT) begin
        w_ir_next    = '0;
        w_valid_next = 1'b0;
        w_ir_pc_next = '0;
        w_delay_next = r_delay - DELAY_W'(1);
        if (r_delay == DELAY_W'(1)) begin
          w_state_next = S_RUN;
        end
      end else begin
`endif
        w_state_next = S_RUN;
        w_ir_next    = iInstruction;
        w_valid_next = 1'b1;
        w_ir_pc_next = w_pc;
`ifdef FETCH_NOP_DELAY_EN
        // The wait begins the cycle after the NOP itself lands in IR.
        if ((get_op(iInstruction) == OP_NOP) && (iInstruction[DELAY_W-1:0] != '0)) begin
          w_delay_next = iInstruction[DELAY_W-1:0];
          w_state_next = S_NOP_WAIT;
        end
      end
`endif
    end
  end

  assign oAddress     = w_pc;
  assign oValid       = r_valid;
  assign oPC          = r_ir_pc;
  assign oOperation   = r_ir[OP_MSB:OP_LSB];
  assign oDestination = r_ir[DST_MSB:DST_LSB];
  assign oSource1     = r_ir[SRC1_MSB:SRC1_LSB];
  assign oSource0     = r_ir[SRC0_MSB:SRC0_LSB];
  assign oImmediate   = r_ir[IMM_MSB:IMM_LSB];

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: behavioural ROM plus a transaction-level fetch model.
module tb_instruction_fetch_unit;

  logic        Clock;
  logic        Reset;
  logic [15:0] oAddress;
  logic [27:0] iInstruction;
  logic        iStall;
  logic        iBranchTaken;
  logic [15:0] iBranchTarget;
  logic        oValid;
  logic [15:0] oPC;
  logic [3:0]  oOperation;
  logic [7:0]  oDestination;
  logic [7:0]  oSource1;
  logic [7:0]  oSource0;
  logic [15:0] oImmediate;

  logic [27:0] rom [0:255];

  // Model: expected PC, expected IR contents, and remaining NOP bubbles.
  logic [15:0] m_pc;
  logic [15:0] m_opc;
  logic        m_valid;
  logic [27:0] m_ir;
  int unsigned m_wait;

  int n_tests = 0;
  int n_fail  = 0;

  instruction_fetch_unit dut (
    .Clock         (Clock),
    .Reset         (Reset),
    .oAddress      (oAddress),
    .iInstruction  (iInstruction),
    .iStall        (iStall),
    .iBranchTaken  (iBranchTaken),
    .iBranchTarget (iBranchTarget),
    .oValid        (oValid),
    .oPC           (oPC),
    .oOperation    (oOperation),
    .oDestination  (oDestination),
    .oSource1      (oSource1),
    .oSource0      (oSource0),
    .oImmediate    (oImmediate)
  );

  assign iInstruction = rom[oAddress[7:0]];

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic step(input logic rst, input logic st, input logic br, input logic [15:0] tgt);
    logic [27:0] word;
    Reset = rst; iStall = st; iBranchTaken = br; iBranchTarget = tgt;
    @(posedge Clock);
    if (rst) begin
      m_pc = 0; m_opc = 0; m_valid = 0; m_ir = 0; m_wait = 0;
    end else if (br) begin
      m_pc = tgt; m_opc = 0; m_valid = 0; m_ir = 0; m_wait = 0;
    end else if (st) begin
      m_wait = m_wait;
    end else if (m_wait != 0) begin
      m_wait = m_wait - 1; m_opc = 0; m_valid = 0; m_ir = 0;
    end else begin
      word = rom[m_pc[7:0]];
      m_ir = word; m_valid = 1; m_opc = m_pc; m_pc = m_pc + 16'd1;
`ifdef FETCH_NOP_DELAY_EN
      if (word[27:24] == 4'h0) m_wait = int'(word[23:0]);
`endif
    end
    #1;
  endtask

  task automatic init_rom();
    logic [3:0] op;
    for (int i = 0; i < 256; i++) begin
      op = 4'($urandom_range(0, 15));
      if (i < 32 && op == 4'h0) op = 4'h1;
      if (op == 4'h0) rom[i] = {4'h0, 24'($urandom_range(0, 3))};
      else            rom[i] = {op, 24'($urandom)};
    end
  endtask

  task automatic test_reset();
    step(1, 0, 0, 16'h0);
    step(1, 0, 0, 16'h0);
    n_tests++;
    if (oAddress !== 16'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0000", oAddress); end
    n_tests++;
    if (oValid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", oValid); end
    n_tests++;
    if (oPC !== 16'h0) begin n_fail++; $display("FAIL reset_pc: got %h want 0000", oPC); end
    n_tests++;
    if ({oOperation, oDestination, oSource1, oSource0, oImmediate} !== 44'h0) begin
      n_fail++; $display("FAIL reset_fields: got %h want 0", {oOperation, oDestination, oSource1, oSource0});
    end
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 0, 16'h0);
      n_tests++;
      if (oAddress !== 16'(i + 1) || oValid !== 1'b1 || oPC !== 16'(i)) begin
        n_fail++;
        $display("FAIL seq_pipe %0d: addr %h valid %b pc %h want addr %h valid 1 pc %h",
                 i, oAddress, oValid, oPC, 16'(i + 1), 16'(i));
      end
      n_tests++;
      if ({oOperation, oDestination, oSource1, oSource0} !== rom[i]) begin
        n_fail++; $display("FAIL seq_fields %0d: got %h want %h", i,
                           {oOperation, oDestination, oSource1, oSource0}, rom[i]);
      end
    end
  endtask

  task automatic test_flush();
    int guard = 0;
    step(1, 0, 0, 16'h0);
    while (!(m_valid && m_opc == 16'd11) && guard < 200) begin
      step(0, 0, 0, 16'h0);
      guard++;
    end
    n_tests++;
    if (oPC !== 16'd11 || oValid !== 1'b1) begin
      n_fail++; $display("FAIL flush_reach: pc %h valid %b want pc 000b valid 1", oPC, oValid);
    end
    step(0, 0, 1, 16'd8);
    n_tests++;
    if (oAddress !== 16'd8 || oValid !== 1'b0) begin
      n_fail++; $display("FAIL flush_bubble: addr %h valid %b want 0008 0", oAddress, oValid);
    end
    step(0, 0, 0, 16'h0);
    n_tests++;
    if (oPC !== 16'd8 || oValid !== 1'b1 ||
        {oOperation, oDestination, oSource1, oSource0} !== rom[8] || oImmediate !== rom[8][15:0]) begin
      n_fail++; $display("FAIL flush_target: pc %h valid %b word %h want 0008 1 %h", oPC, oValid,
                         {oOperation, oDestination, oSource1, oSource0}, rom[8]);
    end
  endtask

  task automatic test_stall();
    logic [15:0] s_pc;
    logic [27:0] s_word;
    step(1, 0, 0, 16'h0);
    for (int i = 0; i < 5 && m_pc != 16'd5; i++) step(0, 0, 0, 16'h0);
    s_pc = oPC;
    s_word = {oOperation, oDestination, oSource1, oSource0};
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 16'h0);
      n_tests++;
      if (oAddress !== 16'd5 || oPC !== s_pc || oValid !== 1'b1 ||
          {oOperation, oDestination, oSource1, oSource0} !== s_word) begin
        n_fail++; $display("FAIL stall_hold %0d: addr %h pc %h word %h want 0005 %h %h", i,
                           oAddress, oPC, {oOperation, oDestination, oSource1, oSource0}, s_pc, s_word);
      end
    end
    step(0, 0, 0, 16'h0);
    n_tests++;
    if (oAddress !== 16'd6 || oPC !== 16'd5 || {oOperation, oDestination, oSource1, oSource0} !== rom[5]) begin
      n_fail++; $display("FAIL stall_resume: addr %h pc %h want 0006 0005", oAddress, oPC);
    end
  endtask

  task automatic test_stall_branch();
    step(0, 1, 1, 16'd2);
    n_tests++;
    if (oAddress !== 16'd2 || oValid !== 1'b0) begin
      n_fail++; $display("FAIL stallbr_redirect: addr %h valid %b want 0002 0", oAddress, oValid);
    end
    step(0, 0, 0, 16'h0);
    n_tests++;
    if (oAddress !== 16'd3 || oValid !== 1'b1 || oPC !== 16'd2 || oOperation !== rom[2][27:24]) begin
      n_fail++; $display("FAIL stallbr_fetch: addr %h valid %b pc %h op %h want 0003 1 0002 %h",
                         oAddress, oValid, oPC, oOperation, rom[2][27:24]);
    end
  endtask

  task automatic test_wrap_and_reset();
    step(0, 0, 1, 16'hFFFF);
    n_tests++;
    if (oAddress !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_load: got %h want ffff", oAddress); end
    step(0, 0, 0, 16'h0);
    n_tests++;
    if (oAddress !== 16'h0 || oPC !== 16'hFFFF || oValid !== 1'b1 ||
        {oOperation, oDestination, oSource1, oSource0} !== rom[255]) begin
      n_fail++; $display("FAIL wrap_next: addr %h pc %h valid %b want 0000 ffff 1", oAddress, oPC, oValid);
    end
    step(0, 1, 0, 16'h0);
    step(0, 1, 0, 16'h0);
    step(1, 1, 0, 16'h0);
    n_tests++;
    if ({oAddress, oValid, oPC, oOperation, oDestination, oSource1, oSource0, oImmediate} !== 77'h0) begin
      n_fail++; $display("FAIL reset_midstall: addr %h valid %b pc %h op %h want all 0",
                         oAddress, oValid, oPC, oOperation);
    end
  endtask

  task automatic test_nop_delay();
    logic [27:0] saved;
    saved = rom[0];
    rom[0] = {4'h0, 24'd4};
    step(1, 0, 0, 16'h0);
    step(0, 0, 0, 16'h0);
    n_tests++;
    if (oAddress !== 16'd1 || oValid !== 1'b1 || oOperation !== 4'h0) begin
      n_fail++; $display("FAIL nop_enter: addr %h valid %b op %h want 0001 1 0", oAddress, oValid, oOperation);
    end
`ifdef FETCH_NOP_DELAY_EN
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 16'h0);
      n_tests++;
      if (oAddress !== 16'd1 || oValid !== 1'b0) begin
        n_fail++; $display("FAIL nop_wait %0d: addr %h valid %b want 0001 0", i, oAddress, oValid);
      end
    end
    step(0, 0, 0, 16'h0);
    n_tests++;
    if (oValid !== 1'b1 || oPC !== 16'd1 || {oOperation, oDestination, oSource1, oSource0} !== rom[1]) begin
      n_fail++; $display("FAIL nop_done: valid %b pc %h want 1 0001", oValid, oPC);
    end
    // Stall during the wait freezes the remaining count.
    step(1, 0, 0, 16'h0);
    step(0, 0, 0, 16'h0);
    step(0, 0, 0, 16'h0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 16'h0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 16'h0);
    n_tests++;
    if (oValid !== 1'b0 || oAddress !== 16'd1) begin
      n_fail++; $display("FAIL nop_stall_freeze: valid %b addr %h want 0 0001", oValid, oAddress);
    end
    step(0, 0, 0, 16'h0);
    n_tests++;
    if (oValid !== 1'b1 || oPC !== 16'd1) begin
      n_fail++; $display("FAIL nop_stall_resume: valid %b pc %h want 1 0001", oValid, oPC);
    end
    // Branch during the wait aborts it.
    step(1, 0, 0, 16'h0);
    step(0, 0, 0, 16'h0);
    step(0, 0, 0, 16'h0);
    step(0, 0, 1, 16'd5);
    step(0, 0, 0, 16'h0);
    n_tests++;
    if (oValid !== 1'b1 || oPC !== 16'd5 || oAddress !== 16'd6) begin
      n_fail++; $display("FAIL nop_abort: valid %b pc %h addr %h want 1 0005 0006", oValid, oPC, oAddress);
    end
`else
    step(0, 0, 0, 16'h0);
    n_tests++;
    if (oAddress !== 16'd2 || oValid !== 1'b1 || oPC !== 16'd1) begin
      n_fail++; $display("FAIL nop_plain: addr %h valid %b pc %h want 0002 1 0001", oAddress, oValid, oPC);
    end
`endif
    rom[0] = saved;
  endtask

  task automatic test_random();
    logic st, br, rs;
    logic [15:0] tgt;
    step(1, 0, 0, 16'h0);
    for (int c = 0; c < 600; c++) begin
      rs  = ($urandom_range(0, 99) < 1);
      st  = ($urandom_range(0, 99) < 20);
      br  = ($urandom_range(0, 99) < 8);
      tgt = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, 255));
      step(rs, st, br, tgt);
      n_tests++;
      if (oAddress !== m_pc || oValid !== m_valid ||
          {oOperation, oDestination, oSource1, oSource0} !== m_ir || oImmediate !== m_ir[15:0] ||
          (m_valid && oPC !== m_opc)) begin
        n_fail++;
        $display("FAIL rand %0d: addr %h valid %b pc %h word %h want addr %h valid %b pc %h word %h",
                 c, oAddress, oValid, oPC, {oOperation, oDestination, oSource1, oSource0},
                 m_pc, m_valid, m_opc, m_ir);
      end
    end
  endtask

  initial begin
    Reset = 1'b1; iStall = 1'b0; iBranchTaken = 1'b0; iBranchTarget = 16'h0;
    m_pc = 0; m_opc = 0; m_valid = 0; m_ir = 0; m_wait = 0;
    init_rom();
    test_reset();
    test_sequential();
    test_flush();
    test_stall();
    test_stall_branch();
    test_wrap_and_reset();
    test_nop_delay();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
